// File: rtl/voxel_addr_pipe.sv
// voxel_addr_pipe: two-stage voxel coordinate to scene-memory address pipeline.
// Stage 1 captures the coordinates and flags out-of-grid values. Stage 2 builds
// the linear index for the transaction's own mapping mode and adds its base.
// Optional feature macro: VOXEL_ADDR_MORTON_EN enables the Morton interleave for
// mode 2. When the macro is undefined, mode 2 maps the same way as ZYX.
module voxel_addr_pipe #(
  parameter int X_BITS = 5,
  parameter int Y_BITS = 5,
  parameter int Z_BITS = 5,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [X_BITS:0]     in_x,
  input  logic [Y_BITS:0]     in_y,
  input  logic [Z_BITS:0]     in_z,
  input  logic [1:0]          in_mode,
  input  logic [ADDR_W-1:0]   in_base,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ADDR_W-1:0]   out_addr,
  output logic                out_oob,
  output logic                out_last,
  output logic [CNT_W-1:0]    oob_count,
  input  logic                oob_clear
);

  localparam int IDX_W = X_BITS + Y_BITS + Z_BITS;

  // Reject parameter sets the address arithmetic cannot represent.
  if (X_BITS < 1 || X_BITS > 16 || Y_BITS < 1 || Y_BITS > 16 ||
      Z_BITS < 1 || Z_BITS > 16) begin : gBadCoordW
    $error("voxel_addr_pipe: coordinate widths must be within 1..16");
  end
  if (ADDR_W < IDX_W || ADDR_W > 32) begin : gBadAddrW
    $error("voxel_addr_pipe: ADDR_W must be >= X_BITS+Y_BITS+Z_BITS and <= 32");
  end
`ifdef VOXEL_ADDR_MORTON_EN
  if (X_BITS != Y_BITS || X_BITS != Z_BITS) begin : gBadMorton
    $error("voxel_addr_pipe: Morton interleave needs X_BITS == Y_BITS == Z_BITS");
  end
`endif

  // Stage 1 registers
  logic                s1Valid_q;
  logic [X_BITS-1:0]   s1X_q;
  logic [Y_BITS-1:0]   s1Y_q;
  logic [Z_BITS-1:0]   s1Z_q;
  logic [1:0]          s1Mode_q;
  logic [ADDR_W-1:0]   s1Base_q;
  logic                s1Last_q;
  logic                s1Oob_q;

  // Stage 2 registers
  logic                s2Valid_q;
  logic [ADDR_W-1:0]   s2Addr_q;
  logic [ADDR_W-1:0]   s2Addr_d;
  logic                s2Oob_q;
  logic                s2Last_q;

  logic [CNT_W-1:0]    oobCount_q;
  logic [CNT_W-1:0]    oobCount_d;

  logic                s2Advance;
  logic                accept;
  logic                inOob;
  logic [IDX_W-1:0]    mappedIdx;
  logic [ADDR_W-1:0]   idxExt;

  assign s2Advance = !s2Valid_q || out_ready;
  assign in_ready  = !s1Valid_q || s2Advance;
  assign accept    = in_valid && in_ready;
  assign inOob     = in_x[X_BITS] | in_y[Y_BITS] | in_z[Z_BITS];

`ifdef VOXEL_ADDR_MORTON_EN
  logic [IDX_W-1:0] mortonIdx;

  // Interleave coordinate bit i into index bits 3i (x), 3i+1 (y), 3i+2 (z).
  always_comb begin
    mortonIdx = '0;
    for (int i = 0; i < X_BITS; i++) begin
      mortonIdx[3*i]     = s1X_q[i];
      mortonIdx[3*i + 1] = s1Y_q[i];
      mortonIdx[3*i + 2] = s1Z_q[i];
    end
  end
`endif

  // Select the linear index for the mode captured with this transaction.
  always_comb begin
    mappedIdx = {s1Z_q, s1Y_q, s1X_q};
    case (s1Mode_q)
      2'd1:    mappedIdx = {s1X_q, s1Y_q, s1Z_q};
`ifdef VOXEL_ADDR_MORTON_EN
      2'd2:    mappedIdx = mortonIdx;
`endif
      default: mappedIdx = {s1Z_q, s1Y_q, s1X_q};
    endcase
  end

  // Zero-extend the index and add the base; the carry out is simply dropped.
  always_comb begin
    idxExt              = '0;
    idxExt[IDX_W-1:0]   = mappedIdx;
    s2Addr_d            = idxExt + s1Base_q;
  end

  // Saturating OOB counter; a clear wins over a same-cycle increment.
  always_comb begin
    oobCount_d = oobCount_q;
    if (oob_clear) begin
      oobCount_d = '0;
    end else if (accept && inOob && (oobCount_q != {CNT_W{1'b1}})) begin
      oobCount_d = oobCount_q + CNT_W'(1);
    end
  end

  // Stage 1 captures on accept and empties when its entry moves to stage 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid_q <= 1'b0;
      s1X_q     <= '0;
      s1Y_q     <= '0;
      s1Z_q     <= '0;
      s1Mode_q  <= '0;
      s1Base_q  <= '0;
      s1Last_q  <= 1'b0;
      s1Oob_q   <= 1'b0;
    end else if (accept) begin
      s1Valid_q <= 1'b1;
      s1X_q     <= in_x[X_BITS-1:0];
      s1Y_q     <= in_y[Y_BITS-1:0];
      s1Z_q     <= in_z[Z_BITS-1:0];
      s1Mode_q  <= in_mode;
      s1Base_q  <= in_base;
      s1Last_q  <= in_last;
      s1Oob_q   <= inOob;
    end else if (s2Advance) begin
      s1Valid_q <= 1'b0;
    end
  end

  // Stage 2 loads from stage 1 whenever it advances and holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2Valid_q <= 1'b0;
      s2Addr_q  <= '0;
      s2Oob_q   <= 1'b0;
      s2Last_q  <= 1'b0;
    end else if (s2Advance) begin
      s2Valid_q <= s1Valid_q;
      if (s1Valid_q) begin
        s2Addr_q <= s2Addr_d;
        s2Oob_q  <= s1Oob_q;
        s2Last_q <= s1Last_q;
      end
    end
  end

  // OOB event counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oobCount_q <= '0;
    end else begin
      oobCount_q <= oobCount_d;
    end
  end

  assign out_valid = s2Valid_q;
  assign out_addr  = s2Addr_q;
  assign out_oob   = s2Oob_q;
  assign out_last  = s2Last_q;
  assign oob_count = oobCount_q;

endmodule

// File: tb/tb_voxel_addr_pipe.sv
// tb_voxel_addr_pipe: table-driven directed vectors plus a randomized stream
// scored against a transaction-level reference model (queue of expected
// outputs, arithmetic address mapping, saturating OOB tally).
module tb_voxel_addr_pipe;

  localparam int XB = 5;
  localparam int YB = 5;
  localparam int ZB = 5;
  localparam int AW = 16;
  localparam int CW = 3;
  localparam int CNT_MAX = 7;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [XB:0]   in_x;
  logic [YB:0]   in_y;
  logic [ZB:0]   in_z;
  logic [1:0]    in_mode;
  logic [AW-1:0] in_base;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic          out_oob;
  logic          out_last;
  logic [CW-1:0] oob_count;
  logic          oob_clear;

  voxel_addr_pipe #(
    .X_BITS(XB), .Y_BITS(YB), .Z_BITS(ZB), .ADDR_W(AW), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_z(in_z),
    .in_mode(in_mode), .in_base(in_base), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_oob(out_oob), .out_last(out_last),
    .oob_count(oob_count), .oob_clear(oob_clear)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic          oob;
    logic          last;
    int            acc;
  } exp_t;

  typedef struct {
    logic [5:0]    x;
    logic [5:0]    y;
    logic [5:0]    z;
    logic [1:0]    mode;
    logic [AW-1:0] base;
    logic          last;
    logic [AW-1:0] expAddr;
    logic          expOob;
    int            expCnt;
  } vec_t;

  exp_t expQ[$];
  vec_t vecs[6];
  int   vectorCount = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   modelCnt = 0;
  bit   lastAccepted;

  // Reference address: linear index from plain arithmetic, then mod 2^AW.
  function automatic logic [AW-1:0] refAddr(logic [5:0] x, logic [5:0] y, logic [5:0] z,
                                           logic [1:0] mode, logic [AW-1:0] base);
    int lx, ly, lz, idx;
    lx = int'(x) % 32;
    ly = int'(y) % 32;
    lz = int'(z) % 32;
    if (mode == 2'd1) begin
      idx = lx * 1024 + ly * 32 + lz;
`ifdef VOXEL_ADDR_MORTON_EN
    end else if (mode == 2'd2) begin
      idx = 0;
      for (int i = 0; i < 5; i++) begin
        idx += ((lx >> i) % 2) * (1 << (3 * i));
        idx += ((ly >> i) % 2) * (1 << (3 * i + 1));
        idx += ((lz >> i) % 2) * (1 << (3 * i + 2));
      end
`endif
    end else begin
      idx = lz * 1024 + ly * 32 + lx;
    end
    return AW'((idx + int'(base)) % 65536);
  endfunction

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectorCount++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, required 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [5:0] x, input logic [5:0] y,
                               input logic [5:0] z, input logic [1:0] mode,
                               input logic [AW-1:0] base, input logic last,
                               input logic outReady, input logic clear);
    in_valid  = valid;
    in_x      = x;
    in_y      = y;
    in_z      = z;
    in_mode   = mode;
    in_base   = base;
    in_last   = last;
    out_ready = outReady;
    oob_clear = clear;
  endtask

  // Compare live outputs with what the transaction model predicts this cycle.
  task automatic checkOutput();
    bit expValid;
    bit expReady;
    expValid = (expQ.size() > 0) && (expQ[0].acc + 2 <= cyc);
    expReady = !((expQ.size() == 2) && !out_ready);
    compare("in_ready", 32'(in_ready), 32'(expReady));
    compare("out_valid", 32'(out_valid), 32'(expValid));
    compare("oob_count", 32'(oob_count), 32'(modelCnt));
    if (expValid && out_valid) begin
      compare("out_addr", 32'(out_addr), 32'(expQ[0].addr));
      compare("out_oob", 32'(out_oob), 32'(expQ[0].oob));
      compare("out_last", 32'(out_last), 32'(expQ[0].last));
    end
  endtask

  // One clock: check, update the model from the handshakes, advance an edge.
  task automatic cycle();
    exp_t e;
    bit   isOob;
    #1;
    checkOutput();
    lastAccepted = in_valid && in_ready;
    if (out_valid && out_ready && expQ.size() > 0) void'(expQ.pop_front());
    isOob = in_x[5] | in_y[5] | in_z[5];
    if (lastAccepted) begin
      e.addr = refAddr(in_x, in_y, in_z, in_mode, in_base);
      e.oob  = isOob;
      e.last = in_last;
      e.acc  = cyc;
      expQ.push_back(e);
    end
    if (oob_clear) modelCnt = 0;
    else if (lastAccepted && isOob && modelCnt < CNT_MAX) modelCnt++;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input logic outReady);
    applyStimulus(1'b0, '0, '0, '0, 2'd0, '0, 1'b0, outReady, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && expQ.size() > 0; i++) begin
      idle(1'b1);
      cycle();
    end
    compare("drain_empty", 32'(expQ.size()), 32'd0);
  endtask

  initial begin
    vecs[0] = '{6'd3,  6'd2, 6'd1,  2'd0, 16'h0000, 1'b0, 16'h0443, 1'b0, 0};
    vecs[1] = '{6'd1,  6'd0, 6'd0,  2'd1, 16'hFC00, 1'b1, 16'h0000, 1'b0, 0};
`ifdef VOXEL_ADDR_MORTON_EN
    vecs[2] = '{6'd1,  6'd1, 6'd1,  2'd2, 16'h0000, 1'b0, 16'h0007, 1'b0, 0};
`else
    vecs[2] = '{6'd1,  6'd1, 6'd1,  2'd2, 16'h0000, 1'b0, 16'h0421, 1'b0, 0};
`endif
    vecs[3] = '{6'h3F, 6'd0, 6'd0,  2'd0, 16'h0000, 1'b1, 16'h001F, 1'b1, 1};
    vecs[4] = '{6'd5,  6'd6, 6'd7,  2'd3, 16'h0010, 1'b0, 16'h1CD5, 1'b0, 1};
    vecs[5] = '{6'd0,  6'd0, 6'h30, 2'd1, 16'h0000, 1'b1, 16'h0010, 1'b1, 2};

    // Reset state
    rst_n = 1'b0;
    idle(1'b0);
    repeat (2) @(negedge clk);
    #1;
    compare("rst_out_valid", 32'(out_valid), 32'd0);
    compare("rst_out_addr", 32'(out_addr), 32'd0);
    compare("rst_out_oob", 32'(out_oob), 32'd0);
    compare("rst_out_last", 32'(out_last), 32'd0);
    compare("rst_oob_count", 32'(oob_count), 32'd0);
    compare("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // Directed table: two-cycle latency and constant expected results
    for (int v = 0; v < 6; v++) begin
      applyStimulus(1'b1, vecs[v].x, vecs[v].y, vecs[v].z, vecs[v].mode,
                    vecs[v].base, vecs[v].last, 1'b1, 1'b0);
      cycle();
      idle(1'b1);
      cycle();
      #1;
      compare($sformatf("vec%0d_valid", v), 32'(out_valid), 32'd1);
      compare($sformatf("vec%0d_addr", v), 32'(out_addr), 32'(vecs[v].expAddr));
      compare($sformatf("vec%0d_oob", v), 32'(out_oob), 32'(vecs[v].expOob));
      compare($sformatf("vec%0d_last", v), 32'(out_last), 32'(vecs[v].last));
      compare($sformatf("vec%0d_cnt", v), 32'(oob_count), 32'(vecs[v].expCnt));
      cycle();
    end
    drain();

    // Clear coinciding with an OOB accept ends at zero
    applyStimulus(1'b1, 6'h3F, 6'd0, 6'd0, 2'd0, 16'h0, 1'b0, 1'b1, 1'b1);
    cycle();
    #1;
    compare("clear_vs_inc", 32'(oob_count), 32'd0);
    drain();

    // Saturation: nine OOB accepts leave the counter at its maximum
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, 6'd0, 6'h20, 6'd0, 2'd0, 16'h0, 1'b0, 1'b1, 1'b0);
      cycle();
    end
    #1;
    compare("cnt_saturate", 32'(oob_count), 32'(CNT_MAX));
    drain();

    // Full stall then release: in_ready drops, then no bubble on release
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 6'(i), 6'(i + 1), 6'(i + 2), 2'd0, 16'h0100, 1'b0, 1'b0, 1'b0);
      cycle();
    end
    applyStimulus(1'b1, 6'd9, 6'd9, 6'd9, 2'd1, 16'h0, 1'b1, 1'b1, 1'b0);
    cycle();
    compare("no_bubble_accept", 32'(lastAccepted), 32'd1);
    drain();

    // Eight back-to-back transactions with random backpressure
    begin
      int sent = 0;
      for (int i = 0; i < 200 && sent < 8; i++) begin
        applyStimulus(1'b1, 6'($urandom_range(0, 31)), 6'($urandom_range(0, 31)),
                      6'($urandom_range(0, 31)), 2'(sent % 3), 16'(sent * 16'h0111),
                      1'(sent == 7), 1'($urandom % 2), 1'b0);
        cycle();
        if (lastAccepted) sent++;
      end
      compare("bp_all_sent", 32'(sent), 32'd8);
    end
    drain();

    // Randomized stream
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom % 4 != 0), 6'($urandom), 6'($urandom), 6'($urandom),
                    2'($urandom), 16'($urandom), 1'($urandom), 1'($urandom % 3 != 0),
                    1'($urandom % 16 == 0));
      cycle();
    end
    drain();

    // Reset with two OOB transactions in flight
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 6'h3F, 6'd1, 6'd2, 2'd0, 16'h0, 1'b1, 1'b0, 1'b0);
      cycle();
    end
    idle(1'b0);
    rst_n = 1'b0;
    #1;
    compare("midrst_out_valid", 32'(out_valid), 32'd0);
    compare("midrst_oob_count", 32'(oob_count), 32'd0);
    compare("midrst_in_ready", 32'(in_ready), 32'd1);
    expQ.delete();
    modelCnt = 0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      idle(1'b1);
      cycle();
    end
    applyStimulus(1'b1, 6'd3, 6'd2, 6'd1, 2'd0, 16'h0, 1'b0, 1'b1, 1'b0);
    cycle();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompares);
    $finish;
  end

endmodule
